// File: rtl/rv32_ifetch_queue_if.sv
// Fetch-unit bundle: redirect request, instruction-memory read bus and decoder handshake.
// The master modport is the prefetch unit's side.
interface rv32_ifetch_queue_if #(
  parameter int LOG2_DEPTH = 2
);
  logic                update_pc;
  logic [31:0]         new_pc;
  logic [31:0]         iaddress;
  logic                iread;
  logic [31:0]         ireaddata;
  logic                iwaitrequest;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [31:0]         instr_pc;
  logic                instr_ready;
  logic [LOG2_DEPTH:0] level;

  modport master (
    input  update_pc, new_pc, ireaddata, iwaitrequest, instr_ready,
    output iaddress, iread, instr_valid, instr, instr_pc, level
  );

  modport slave (
    output update_pc, new_pc, ireaddata, iwaitrequest, instr_ready,
    input  iaddress, iread, instr_valid, instr, instr_pc, level
  );
endinterface

// File: rtl/rv32_ifetch_queue.sv
// RV32 instruction prefetch queue: credit-limited sequential word fetch into a
// DEPTH-entry FIFO of {instruction, pc}, flushed and restarted by a PC redirect.
module rv32_ifetch_queue #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4,
  parameter int          LOG2_DEPTH   = 2
) (
  input  logic                clk,
  input  logic                reset,
  rv32_ifetch_queue_if.master bus
);
  localparam int OCC_W = LOG2_DEPTH + 1;

  logic [31:0]           fetch_pc_q, fetch_pc_d;
  logic [31:0]           ret_pc_q, ret_pc_d;
  logic                  inflight_q, inflight_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] word_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [OCC_W:0] credit_used;
  logic           has_room;
  logic           accept;
  logic           push;
  logic           pop;

  // Counting the in-flight read as occupied guarantees its return always has a slot.
  assign credit_used = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
  assign has_room    = credit_used < (OCC_W + 1)'(DEPTH);

  assign bus.iaddress    = bus.update_pc ? {bus.new_pc[31:2], 2'b00} : fetch_pc_q;
  assign bus.iread       = ~reset & (bus.update_pc | has_room);
  assign accept          = bus.iread & ~bus.iwaitrequest;
  assign push            = inflight_q & ~bus.update_pc & ~reset;
  assign bus.instr_valid = ~reset & (occ_q != '0) & ~bus.update_pc;
  assign pop             = bus.instr_valid & bus.instr_ready;

  assign bus.instr    = word_mem[rd_ptr_q];
  assign bus.instr_pc = pc_mem[rd_ptr_q];
  assign bus.level    = occ_q;

  always_comb begin
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = accept;
    ret_pc_d   = ret_pc_q;
    // Without acceptance the current address is held, so a redirect survives a stall.
    fetch_pc_d = bus.iaddress;

    if (accept) begin
      ret_pc_d   = bus.iaddress;
      fetch_pc_d = bus.iaddress + 32'd4;
    end

    if (bus.update_pc) begin
      occ_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_VECTOR;
      ret_pc_q   <= RESET_VECTOR;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      ret_pc_q   <= ret_pc_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr_q] <= bus.ireaddata;
      pc_mem[wr_ptr_q]   <= ret_pc_q;
    end
  end
endmodule
